// File: rtl/high_throughput_pkg.sv
// Shared constants for the high-throughput controller slice.
package high_throughput_pkg;

   localparam int unsigned ByteWidth            = 8;
   localparam int unsigned DefReplicationFactor = 12;
   localparam int unsigned DefPipelineLatency   = 2;
   localparam int unsigned DefFifoDepth         = 16;
   localparam int unsigned StatsWidth           = 16;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with show-ahead head output and registered occupancy count.
// Depth must be a power of two so the pointers wrap naturally.
module sync_fifo #(
   parameter int unsigned Width = 8,
   parameter int unsigned Depth = 16
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       push_i,
   input  logic [Width-1:0]           wdata_i,
   input  logic                       pop_i,
   output logic [Width-1:0]           rdata_o,
   output logic [$clog2(Depth):0]     count_o
);

   localparam int unsigned AddrW = $clog2(Depth);

   logic [Width-1:0] mem_q [Depth];
   logic [AddrW-1:0] wptr_q, wptr_d;
   logic [AddrW-1:0] rptr_q, rptr_d;
   logic [AddrW:0]   count_q, count_d;

   // Pointer and occupancy next-state.
   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (push_i) begin
         wptr_d = wptr_q + AddrW'(1);
      end
      if (pop_i) begin
         rptr_d = rptr_q + AddrW'(1);
      end
      count_d = count_q + (AddrW+1)'(push_i) - (AddrW+1)'(pop_i);
   end

   // Pointer and occupancy registers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // Storage array; contents need no reset since the head is gated when empty.
   always_ff @(posedge clk_i) begin
      if (push_i) begin
         mem_q[wptr_q] <= wdata_i;
      end
   end

   // Head is forced to zero while empty so no stale byte is ever visible.
   always_comb begin
      rdata_o = '0;
      if (count_q != '0) begin
         rdata_o = mem_q[rptr_q];
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/high_throughput_controller.sv
// Flow controller: registers replicated words into the processor, captures its
// results after a fixed latency and queues them, credit-protected, for the UART.
// Optional statistics counters: define HIGH_THROUGHPUT_CONTROLLER_STATS_EN.
module high_throughput_controller
   import high_throughput_pkg::*;
#(
   parameter int unsigned REPLICATION_FACTOR = DefReplicationFactor,
   parameter int unsigned PIPELINE_LATENCY   = DefPipelineLatency,
   parameter int unsigned FIFO_DEPTH         = DefFifoDepth
) (
   input  logic                                   clock,
   input  logic                                   reset,
   input  logic [ByteWidth*REPLICATION_FACTOR-1:0] in_data,
   input  logic                                   in_valid,
   output logic                                   in_ready,
   output logic                                   proc_enable,
   output logic [ByteWidth*REPLICATION_FACTOR-1:0] proc_data_in,
   input  logic [ByteWidth-1:0]                   proc_data_out,
   output logic [ByteWidth-1:0]                   out_data,
   output logic                                   out_valid,
   input  logic                                   out_ready,
   output logic [StatsWidth-1:0]                  words_accepted,
   output logic [StatsWidth-1:0]                  bytes_sent
);

   localparam int unsigned WordW = ByteWidth * REPLICATION_FACTOR;
   localparam int unsigned CredW = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned CntW  = $clog2(FIFO_DEPTH) + 1;

   logic [CredW-1:0]            credits_q, credits_d;
   logic                        proc_enable_q, proc_enable_d;
   logic [WordW-1:0]            proc_data_in_q, proc_data_in_d;
   logic [PIPELINE_LATENCY-1:0] vld_q, vld_d;
   logic                        accept, pop, push;
   logic [CntW-1:0]             fifo_count;

   assign in_ready     = (credits_q != '0);
   assign accept       = in_valid & in_ready;
   assign out_valid    = (fifo_count != '0);
   assign pop          = out_valid & out_ready;
   assign push         = vld_q[PIPELINE_LATENCY-1];
   assign proc_enable  = proc_enable_q;
   assign proc_data_in = proc_data_in_q;

   // Credits count slots not yet claimed by a queued or in-flight result.
   always_comb begin
      credits_d = credits_q;
      unique case ({accept, pop})
         2'b10:   credits_d = credits_q - CredW'(1);
         2'b01:   credits_d = credits_q + CredW'(1);
         default: credits_d = credits_q;
      endcase
   end

   // Input register, enable strobe and result-tracking shift register.
   always_comb begin
      proc_enable_d  = accept;
      proc_data_in_d = proc_data_in_q;
      if (accept) begin
         proc_data_in_d = in_data;
      end
      vld_d    = vld_q;
      vld_d[0] = proc_enable_q;
      for (int i = 1; i < int'(PIPELINE_LATENCY); i++) begin
         vld_d[i] = vld_q[i-1];
      end
   end

   // Control state registers; reset discards everything in flight.
   always_ff @(posedge clock) begin
      if (!reset) begin
         credits_q      <= CredW'(FIFO_DEPTH);
         proc_enable_q  <= 1'b0;
         proc_data_in_q <= '0;
         vld_q          <= '0;
      end else begin
         credits_q      <= credits_d;
         proc_enable_q  <= proc_enable_d;
         proc_data_in_q <= proc_data_in_d;
         vld_q          <= vld_d;
      end
   end

   sync_fifo #(
      .Width (ByteWidth),
      .Depth (FIFO_DEPTH)
   ) u_result_fifo (
      .clk_i   (clock),
      .rst_ni  (reset),
      .push_i  (push),
      .wdata_i (proc_data_out),
      .pop_i   (pop),
      .rdata_o (out_data),
      .count_o (fifo_count)
   );

`ifdef HIGH_THROUGHPUT_CONTROLLER_STATS_EN
   logic [StatsWidth-1:0] words_q, words_d;
   logic [StatsWidth-1:0] bytes_q, bytes_d;

   // Wrapping accept and pop counters.
   always_comb begin
      words_d = words_q;
      bytes_d = bytes_q;
      if (accept) begin
         words_d = words_q + StatsWidth'(1);
      end
      if (pop) begin
         bytes_d = bytes_q + StatsWidth'(1);
      end
   end

   // Statistics registers.
   always_ff @(posedge clock) begin
      if (!reset) begin
         words_q <= '0;
         bytes_q <= '0;
      end else begin
         words_q <= words_d;
         bytes_q <= bytes_d;
      end
   end

   assign words_accepted = words_q;
   assign bytes_sent     = bytes_q;
`else
   assign words_accepted = '0;
   assign bytes_sent     = '0;
`endif

endmodule

// File: doc/high_throughput_controller.md
# high_throughput_controller

Flow controller between the `replicate` stage and the `high_throughput_stateful_processor`, and between the processor and the UART transmitter. It accepts one replicated word per valid/ready handshake and registers it into the processor. It pulses the processor `enable` once per accepted word and captures the processor's byte result after a fixed pipeline latency. Captured bytes go into a credit-protected FIFO that drains into the UART `transmit` valid/ready interface, so no result is dropped or duplicated under UART back-pressure.

## Interface
Parameters:
- `REPLICATION_FACTOR`, 12, number of bytes in one replicated input word.
- `PIPELINE_LATENCY`, 2, cycles from a processor enable cycle to the cycle its `data_out` is valid; legal range ≥1.
- `FIFO_DEPTH`, 16, result FIFO entries; power of two, ≥2.

Ports:
- `clock`  in  1  single clock domain.
- `reset`  in  1  synchronous, active-low (0 = reset, sampled on rising `clock`).
- `in_data`  in  8*REPLICATION_FACTOR  replicated word.
- `in_valid`  in  1  upstream word valid.
- `in_ready`  out  1  controller can accept a word.
- `proc_enable`  out  1  one-cycle advance strobe to the processor.
- `proc_data_in`  out  8*REPLICATION_FACTOR  registered word to the processor.
- `proc_data_out`  in  8  processor result byte.
- `out_data`  out  8  byte to the UART transmit port.
- `out_valid`  out  1  `out_data` valid.
- `out_ready`  in  1  UART accepts the byte.
- `words_accepted`  out  16  stats counter (see Configuration).
- `bytes_sent`  out  16  stats counter (see Configuration).

## Operation
- Credit counter `credits` holds free FIFO slots minus in-flight results. It resets to FIFO_DEPTH.
- `in_ready` = (`credits` != 0). This is combinational from registered state and does not depend on `in_valid`.
- Accept (`in_valid & in_ready`) in cycle T:
  - `proc_data_in` <= `in_data`.
  - `proc_enable` = 1 in cycle T+1 only.
  - `credits` decrements.
- Valid shift register, length PIPELINE_LATENCY, tracks enable pulses. When a tracked pulse reaches cycle T+1+PIPELINE_LATENCY, `proc_data_out` is sampled in that cycle and pushed into the FIFO.
- FIFO pop (`out_valid & out_ready`) increments `credits`.
- Accept and pop in the same cycle leaves `credits` unchanged.
- `out_valid` = FIFO non-empty. `out_data` = FIFO head. Both hold stable until popped.
- Full: the credit scheme guarantees a push never meets a full FIFO. Push and pop in the same cycle at full is legal.
- Empty: a push into an empty FIFO makes `out_valid` high in the next cycle. A pop is never issued while empty.
- `proc_data_in` holds its last value between accepts. The processor ignores it while `proc_enable` = 0.
- Reset mid-operation clears the following:
  - FIFO and in-flight pipeline tracking; results already in flight are discarded.
  - `credits` returns to FIFO_DEPTH.
  - Stats counters.

## Timing
- Reset values:
  - `in_ready` = 1
  - `proc_enable` = 0
  - `proc_data_in` = 0
  - `out_valid` = 0
  - `out_data` = 0
  - `words_accepted` = 0
  - `bytes_sent` = 0
- Latency: accept in cycle T → `out_valid` first high in cycle T+2+PIPELINE_LATENCY, provided the FIFO was empty.
- Throughput: one word per cycle while credits are available and `out_ready` = 1.
- With `out_ready` held 0, exactly FIFO_DEPTH words are accepted, then `in_ready` = 0.

## Configuration
- `HIGH_THROUGHPUT_CONTROLLER_STATS_EN` defined:
  - `words_accepted` increments on each accept.
  - `bytes_sent` increments on each pop.
  - Both are 16-bit and wrap from 0xFFFF to 0.
- Not defined: both ports are driven constant 0 and no counter logic is synthesized.

## Structure
- Shared package `high_throughput_pkg` holds:
  - the byte width constant (8)
  - the default REPLICATION_FACTOR, PIPELINE_LATENCY and FIFO_DEPTH
  - the stats counter width (16)
- Sub-module `sync_fifo`: parameterized width and depth, show-ahead head output, registered `count`.
- The controller instantiates `sync_fifo` with width 8, depth FIFO_DEPTH.

## Test plan
- Reset held low for 3 cycles → all outputs at reset values; release → `in_ready` = 1.
- Single word `0x0102…0C` accepted at T, processor model echoes byte 0x0C → `proc_enable` high only at T+1; `out_data` = 0x0C with `out_valid` at T+4 (PIPELINE_LATENCY = 2).
- `out_ready` = 0, 20 consecutive valid words → exactly 16 accepted, `in_ready` = 0 from then on. Set `out_ready` = 1 → 16 bytes drain in order, then `in_ready` returns to 1.
- Random `in_valid` / `out_ready` over 1000 words with a scoreboard → byte order and count match, no drops or duplicates.
- Reset asserted with 3 results in flight and 5 in the FIFO → `out_valid` = 0 next cycle; no stale byte appears after release.
- With STATS_EN, 70000 accepted words → `words_accepted` = 70000 mod 65536 = 4464. Without STATS_EN → both stats ports stay 0.
